// File: rtl/avalon_width_bridge.sv
// avalon_width_bridge: narrow WIDTHD slave to WIDTHD*RATIO master Avalon-MM bridge.
// Define WIDTH_BRIDGE_TAG_CHECK_EN to tag the read latch and refetch on a miss.
module avalon_width_bridge #(
    parameter int WIDTHA = 8,
    parameter int WIDTHD = 16,
    parameter int RATIO  = 4
) (
    input  logic                                clock,
    input  logic                                sreset,
    input  logic [WIDTHA-1:0]                   s_address,
    input  logic [WIDTHD/8-1:0]                 s_byteenable,
    input  logic [WIDTHD-1:0]                   s_writedata,
    output logic [WIDTHD-1:0]                   s_readdata,
    input  logic                                s_read,
    input  logic                                s_write,
    output logic                                s_waitrequest,
    output logic [WIDTHA-$clog2(RATIO)-1:0]     d_address,
    output logic [WIDTHD*RATIO/8-1:0]           d_byteenable,
    output logic [WIDTHD*RATIO-1:0]             d_writedata,
    input  logic [WIDTHD*RATIO-1:0]             d_readdata,
    output logic                                d_read,
    output logic                                d_write,
    input  logic                                d_waitrequest
);
    localparam int L  = $clog2(RATIO);
    localparam int BL = WIDTHD / 8;
    localparam int BB = BL * RATIO;
    localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ACK = 2'd3;

    logic [1:0]              state;
    logic [L-1:0]            lane;
    logic [WIDTHA-L-1:0]     word;
    logic [BB-1:0]           be_acc;
    logic [BB-1:0]           be_next;
    logic [WIDTHD*RATIO-1:0] rd_latch;
    logic                    miss, rd_fetch, wr_top;

    assign lane = s_address[L-1:0];
    assign word = s_address[WIDTHA-1:L];

`ifdef WIDTH_BRIDGE_TAG_CHECK_EN
    logic [WIDTHA-L-1:0] tag;
    logic                valid;
    assign miss = !valid || tag != word;
`else
    assign miss = 1'b0;
`endif

    // a write always wins over a simultaneous read
    assign rd_fetch      = s_read && !s_write && (lane == '0 || miss);
    assign wr_top        = s_write && lane == '1;
    assign s_waitrequest = state == IDLE ? wr_top || rd_fetch : state != ACK;
    assign s_readdata    = rd_latch[lane*WIDTHD +: WIDTHD];
    assign be_next       = be_acc | (BB'(s_byteenable) << ((RATIO-1)*BL));

    always_ff @(posedge clock) begin
        if (sreset) begin
            state        <= IDLE;
            d_read       <= 1'b0;
            d_write      <= 1'b0;
            d_address    <= '0;
            d_writedata  <= '0;
            d_byteenable <= '0;
            rd_latch     <= '0;
            be_acc       <= '0;
`ifdef WIDTH_BRIDGE_TAG_CHECK_EN
            tag          <= '0;
            valid        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_write) begin
                        d_writedata[lane*WIDTHD +: WIDTHD] <= s_writedata;
                        if (lane == '1) begin
                            d_address    <= word;
                            d_byteenable <= be_next;
                            d_write      <= 1'b1;
                            state        <= WR;
                        end else begin
                            be_acc[lane*BL +: BL] <= be_acc[lane*BL +: BL] | s_byteenable;
                        end
                    end else if (rd_fetch) begin
                        d_address <= word;
                        d_read    <= 1'b1;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (!d_waitrequest) begin
                        rd_latch <= d_readdata;
                        d_read   <= 1'b0;
                        state    <= ACK;
`ifdef WIDTH_BRIDGE_TAG_CHECK_EN
                        tag      <= d_address;
                        valid    <= 1'b1;
`endif
                    end
                end
                WR: begin
                    if (!d_waitrequest) begin
                        d_write <= 1'b0;
                        be_acc  <= '0;
                        state   <= ACK;
`ifdef WIDTH_BRIDGE_TAG_CHECK_EN
                        if (tag == d_address)
                            valid <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
